// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch/exception-entry sequencer and its decoder peer:
// sequencer states, exception cause codes, IR field positions and the default vector base.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_EXC_RD   = 3'd4,
    ST_EXC_WAIT = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    EXC_INVALID_OP = 2'd0,
    EXC_OVERFLOW   = 2'd1,
    EXC_DIV_ZERO   = 2'd2,
    EXC_RESERVED   = 2'd3
  } exc_cause_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] EXC_BASE_DEFAULT = 32'd253;

  // The reserved cause shares the invalid-opcode handler.
  function automatic logic [1:0] exc_vector_index(input logic [1:0] cause);
    return (cause == 2'(EXC_RESERVED)) ? 2'(EXC_INVALID_OP) : cause;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port plus the opcode/funct handshake between the fetch sequencer
// (master) and the memory/control decoder side (slave).
interface fetch_sequencer_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_addr, mem_rd,
    input  mem_rdata,
    output opcode, funct, rs, rt, rd, shamt, imm, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_rdata,
    input  opcode, funct, rs, rt, rd, shamt, imm, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating 3-bit memory-latency timer; done flags the last cycle of a MEM_LAT wait.
module fetch_wait_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != 3'd7)) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign done = en && (cnt == 3'(MEM_LAT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle instruction fetch and exception-entry sequencer owning PC, EPC and IR.
// Optional FETCH_PERF_CNT_EN adds retired_cnt/exc_cnt performance counters.
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] EXC_BASE = EXC_BASE_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  fetch_sequencer_if.master  bus,
  input  logic [31:0]        next_pc,
  input  logic               next_pc_valid,
  input  logic               exc_valid,
  input  logic [1:0]         exc_cause,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        epc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [15:0]        exc_cnt
`endif
);

  fetch_state_e state, state_nx;
  logic         run;
  logic [31:0]  ir;
  logic [1:0]   cause_q;
  logic [31:0]  next_pc_al;
  logic [31:0]  mem_addr_c;
  logic         timer_clr, timer_en, timer_done;
  logic         ir_ld, pc_ld_next, pc_ld_vec, epc_ld;

  assign next_pc_al = next_pc & 32'hFFFF_FFFC;

  fetch_wait_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .done    (timer_done)
  );

  // run holds the machine idle for the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run   <= 1'b0;
      state <= ST_FETCH;
    end else begin
      run <= 1'b1;
      if (run) state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    ir_ld      = 1'b0;
    pc_ld_next = 1'b0;
    pc_ld_vec  = 1'b0;
    epc_ld     = 1'b0;
    case (state)
      ST_FETCH: begin
        timer_clr = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (timer_done) begin
          ir_ld    = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.instr_ready) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        // Exception has priority; a simultaneous next_pc is dropped.
        if (exc_valid) begin
          epc_ld   = 1'b1;
          state_nx = ST_EXC_RD;
        end else if (next_pc_valid) begin
          pc_ld_next = 1'b1;
          state_nx   = ST_FETCH;
        end
      end
      ST_EXC_RD: begin
        timer_clr = 1'b1;
        state_nx  = ST_EXC_WAIT;
      end
      ST_EXC_WAIT: begin
        timer_en = 1'b1;
        if (timer_done) begin
          pc_ld_vec = 1'b1;
          state_nx  = ST_FETCH;
        end
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= RESET_PC;
      epc     <= '0;
      ir      <= '0;
      cause_q <= '0;
    end else begin
      if (ir_ld) ir <= bus.mem_rdata;
      if (epc_ld) begin
        epc     <= pc;
        cause_q <= exc_vector_index(exc_cause);
      end
      if (pc_ld_next)     pc <= next_pc_al;
      else if (pc_ld_vec) pc <= {24'b0, bus.mem_rdata[7:0]};
    end
  end

  always_comb begin
    mem_addr_c = '0;
    if (run && (state == ST_FETCH))       mem_addr_c = pc;
    else if (run && (state == ST_EXC_RD)) mem_addr_c = EXC_BASE + 32'(cause_q);
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_rd      = run && ((state == ST_FETCH) || (state == ST_EXC_RD));
  assign bus.instr_valid = (state == ST_ISSUE);
  assign bus.opcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.rs          = ir[RS_MSB:RS_LSB];
  assign bus.rt          = ir[RT_MSB:RT_LSB];
  assign bus.rd          = ir[RD_MSB:RD_LSB];
  assign bus.shamt       = ir[SHAMT_MSB:SHAMT_LSB];
  assign bus.funct       = ir[FUNCT_MSB:FUNCT_LSB];
  assign bus.imm         = ir[IMM_MSB:IMM_LSB];
  assign pc_plus4        = pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt <= '0;
      exc_cnt     <= '0;
    end else begin
      if (pc_ld_next) retired_cnt <= retired_cnt + 32'd1;
      if (epc_ld)     exc_cnt     <= exc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: MEM_LAT=1 instance with directed and random instruction
// flows against a PC/EPC model, plus a MEM_LAT=3 instance for latency and async reset.
module tb_fetch_sequencer;

  localparam int          L1 = 1;
  localparam int          L3 = 3;
  localparam logic [31:0] XB = 32'd253;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  fetch_sequencer_if bus1();
  fetch_sequencer_if bus3();

  logic [31:0] next_pc1, next_pc3, pc1, pc41, epc1, pc3, pc43, epc3;
  logic        npv1, npv3, exv1, exv3;
  logic [1:0]  cause1, cause3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] ret1, ret3;
  logic [15:0] exc1c, exc3c;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [0:255];
  logic [7:0]  vec  [0:2];
  logic [31:0] m_pc, m_epc;
  int          m_ret, m_exc;

  fetch_sequencer #(.MEM_LAT(L1), .EXC_BASE(XB), .RESET_PC(32'd0)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(bus1),
    .next_pc(next_pc1), .next_pc_valid(npv1), .exc_valid(exv1), .exc_cause(cause1),
    .pc(pc1), .pc_plus4(pc41), .epc(epc1)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt(ret1), .exc_cnt(exc1c)
`endif
  );

  fetch_sequencer #(.MEM_LAT(L3), .EXC_BASE(XB), .RESET_PC(32'd0)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .bus(bus3),
    .next_pc(next_pc3), .next_pc_valid(npv3), .exc_valid(exv3), .exc_cause(cause3),
    .pc(pc3), .pc_plus4(pc43), .epc(epc3)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt(ret3), .exc_cnt(exc3c)
`endif
  );

  // Memory contents: handler bytes at the vector addresses, instruction words elsewhere.
  function automatic logic [31:0] memw(input logic [31:0] a);
    int k;
    if (a >= XB && a <= XB + 32'd2) begin
      k = int'(a - XB);
      return {24'h5A5A5A, vec[k]};
    end
    return imem[a[9:2]];
  endfunction

  // Read data is only meaningful exactly MEM_LAT cycles after the strobe.
  logic [32:0] p1 [0:7];
  logic [32:0] p3 [0:7];
  always @(posedge clk) begin
    p1[0] <= {bus1.mem_rd, bus1.mem_addr};
    p3[0] <= {bus3.mem_rd, bus3.mem_addr};
    for (int k = 1; k < 8; k++) begin
      p1[k] <= p1[k-1];
      p3[k] <= p3[k-1];
    end
  end
  assign bus1.mem_rdata = p1[L1-1][32] ? memw(p1[L1-1][31:0]) : 32'hDEADBEEF;
  assign bus3.mem_rdata = p3[L3-1][32] ? memw(p3[L3-1][31:0]) : 32'hDEADBEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields1(input string tag, input logic [31:0] w);
    chk({tag, "_opcode"}, 32'(bus1.opcode), 32'(w[31:26]));
    chk({tag, "_rs"},     32'(bus1.rs),     32'(w[25:21]));
    chk({tag, "_rt"},     32'(bus1.rt),     32'(w[20:16]));
    chk({tag, "_rd"},     32'(bus1.rd),     32'(w[15:11]));
    chk({tag, "_shamt"},  32'(bus1.shamt),  32'(w[10:6]));
    chk({tag, "_funct"},  32'(bus1.funct),  32'(w[5:0]));
    chk({tag, "_imm"},    32'(bus1.imm),    32'(w[15:0]));
  endtask

  // Entered at a sample point where dut1 should be strobing the fetch of m_pc.
  task automatic do_instr1(input bit use_exc, input bit both, input logic [1:0] cs,
                           input logic [31:0] npc, input int hold, input int idle);
    logic [31:0] w;
    int n;
    int eff;
    w = memw(m_pc);
    chk("fetch_rd", 32'(bus1.mem_rd), 32'd1);
    chk("fetch_addr", bus1.mem_addr, m_pc);
    chk("pc", pc1, m_pc);
    chk("pc_plus4", pc41, m_pc + 32'd4);
    chk("epc", epc1, m_epc);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk("rd_gap", 32'(bus1.mem_rd), 32'd0);
    end while (!bus1.instr_valid && n < 20);
    chk("fetch_latency", n, L1 + 1);
    chk_fields1("issue", w);
    for (int i = 0; i < hold; i++) begin
      exv1     = 1'($urandom_range(0, 1));
      npv1     = 1'($urandom_range(0, 1));
      next_pc1 = $urandom;
      step();
      chk("hold_valid", 32'(bus1.instr_valid), 32'd1);
      chk("hold_fields", {6'b0, bus1.rs, bus1.rt, bus1.imm}, {6'b0, w[25:0]});
      chk("hold_opfn", {20'b0, bus1.opcode, bus1.funct}, {20'b0, w[31:26], w[5:0]});
    end
    exv1 = 1'b0;
    npv1 = 1'b0;
    bus1.instr_ready = 1'b1;
    step();
    bus1.instr_ready = 1'b0;
    chk("exec_valid", 32'(bus1.instr_valid), 32'd0);
    chk("exec_fields", {6'b0, bus1.rs, bus1.rt, bus1.imm}, {6'b0, w[25:0]});
    for (int i = 0; i < idle; i++) begin
      step();
      chk("exec_idle_rd", 32'(bus1.mem_rd), 32'd0);
      chk("exec_idle_pc", pc1, m_pc);
    end
    exv1     = use_exc;
    cause1   = cs;
    next_pc1 = npc;
    npv1     = !use_exc || both;
    step();
    exv1     = 1'b0;
    npv1     = 1'b0;
    next_pc1 = $urandom;
    if (use_exc) begin
      eff   = (cs == 2'd3) ? 0 : int'(cs);
      m_epc = m_pc;
      m_exc++;
      chk("exc_epc", epc1, m_epc);
      chk("exc_rd", 32'(bus1.mem_rd), 32'd1);
      chk("exc_addr", bus1.mem_addr, XB + 32'(eff));
      chk("exc_pc_hold", pc1, m_pc);
`ifdef FETCH_PERF_CNT_EN
      chk("exc_cnt", 32'(exc1c), 32'(m_exc & 16'hFFFF));
`endif
      for (int i = 0; i < L1; i++) begin
        step();
        chk("exc_wait_rd", 32'(bus1.mem_rd), 32'd0);
      end
      step();
      m_pc = {24'b0, vec[eff]};
    end else begin
      m_pc = npc & ~32'd3;
      m_ret++;
`ifdef FETCH_PERF_CNT_EN
      chk("retired_cnt", ret1, 32'(m_ret));
`endif
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h014B4820;
    vec[0]  = 8'($urandom);
    vec[1]  = 8'h7C;
    vec[2]  = 8'($urandom);
    rst1_n = 1'b0; rst3_n = 1'b0;
    bus1.instr_ready = 1'b0; bus3.instr_ready = 1'b0;
    exv1 = 1'b0; npv1 = 1'b0; cause1 = 2'd0; next_pc1 = '0;
    exv3 = 1'b0; npv3 = 1'b0; cause3 = 2'd0; next_pc3 = '0;
    m_pc = 32'd0; m_epc = 32'd0; m_ret = 0; m_exc = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc1, 32'd0);
    chk("rst_pc_plus4", pc41, 32'd4);
    chk("rst_epc", epc1, 32'd0);
    chk("rst_valid", 32'(bus1.instr_valid), 32'd0);
    chk("rst_mem_rd", 32'(bus1.mem_rd), 32'd0);
    chk("rst_mem_addr", bus1.mem_addr, 32'd0);
    chk_fields1("rst", 32'd0);

    @(negedge clk);
    rst1_n = 1'b1;
    step();

    do_instr1(1'b0, 1'b0, 2'd0, 32'h0000_0013, 5, 0);
    do_instr1(1'b0, 1'b0, 2'd0, 32'h0000_0040, 1, 1);
    do_instr1(1'b1, 1'b1, 2'd1, $urandom, 0, 0);
    do_instr1(1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc41, 32'd0);
    do_instr1(1'b1, 1'b0, 2'd3, $urandom, 1, 0);
    for (int t = 0; t < 25; t++) begin
      do_instr1(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // MEM_LAT=3 instance: issue latency, then asynchronous reset in the middle of WAIT.
    @(negedge clk);
    rst3_n = 1'b1;
    step();
    chk("l3_rd", 32'(bus3.mem_rd), 32'd1);
    chk("l3_addr", bus3.mem_addr, 32'd0);
    n = 0;
    do begin step(); n++; end while (!bus3.instr_valid && n < 20);
    chk("l3_latency", n, L3 + 1);
    chk("l3_opcode", 32'(bus3.opcode), 32'(imem[0][31:26]));
    chk("l3_funct", 32'(bus3.funct), 32'(imem[0][5:0]));
    bus3.instr_ready = 1'b1;
    step();
    bus3.instr_ready = 1'b0;
    next_pc3 = 32'h0000_0022;
    npv3 = 1'b1;
    step();
    npv3 = 1'b0;
    chk("l3_fetch2_addr", bus3.mem_addr, 32'h20);
    step();
    #2;
    rst3_n = 1'b0;
    #1;
    chk("l3_arst_pc", pc3, 32'd0);
    chk("l3_arst_epc", epc3, 32'd0);
    chk("l3_arst_valid", 32'(bus3.instr_valid), 32'd0);
    chk("l3_arst_rd", 32'(bus3.mem_rd), 32'd0);
    chk("l3_arst_addr", bus3.mem_addr, 32'd0);
    chk("l3_arst_opcode", 32'(bus3.opcode), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    step();
    chk("l3_restart_rd", 32'(bus3.mem_rd), 32'd1);
    chk("l3_restart_addr", bus3.mem_addr, 32'd0);
    n = 0;
    do begin step(); n++; end while (!bus3.instr_valid && n < 20);
    chk("l3_restart_latency", n, L3 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
